sync_fifo_buffer: RTL and testbench

Single-clock, parametrised FIFO that combines storage, read/write pointers and status generation into one block; it is the single-clock-domain successor to the team's dual-clock FIFO memory. It adds pointer management, occupancy count, registered read data with a valid strobe, programmable almost-full/almost-empty flags and optional error flags. It is used wherever producer and consumer share one clock, such as datapath staging and command queues.

---
 rtl/sync_fifo_buffer_if.sv | 46 ++++
 rtl/sync_fifo_buffer.sv | 116 +++++++++++
 tb/tb_sync_fifo_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_buffer_if.sv
// Handshake and status bundle for sync_fifo_buffer.
// master: the producer/consumer side. slave: the FIFO itself.
// The overflow_o/underflow_o signals exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_buffer_if #(
    parameter int data_size    = 8,
    parameter int address_size = 3
);
    logic                    write_en_i;
    logic [data_size-1:0]    write_data_i;
    logic                    read_en_i;
    logic [data_size-1:0]    read_data_o;
    logic                    read_valid_o;
    logic                    full_o;
    logic                    empty_o;
    logic                    almost_full_o;
    logic                    almost_empty_o;
    logic [address_size:0]   count_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                    overflow_o;
    logic                    underflow_o;

    modport master (
        output write_en_i, write_data_i, read_en_i,
        input  read_data_o, read_valid_o, full_o, empty_o,
               almost_full_o, almost_empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  write_en_i, write_data_i, read_en_i,
        output read_data_o, read_valid_o, full_o, empty_o,
               almost_full_o, almost_empty_o, count_o, overflow_o, underflow_o
    );
`else
    modport master (
        output write_en_i, write_data_i, read_en_i,
        input  read_data_o, read_valid_o, full_o, empty_o,
               almost_full_o, almost_empty_o, count_o
    );

    modport slave (
        input  write_en_i, write_data_i, read_en_i,
        output read_data_o, read_valid_o, full_o, empty_o,
               almost_full_o, almost_empty_o, count_o
    );
`endif
endinterface

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO: storage, wrap-bit pointers, occupancy count,
// registered read data with a valid strobe and programmable almost flags.
// Optional sticky overflow/underflow flags are built when the macro
// SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_buffer #(
    parameter int data_size          = 8,
    parameter int address_size       = 3,
    parameter int almost_full_level  = 6,
    parameter int almost_empty_level = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    sync_fifo_buffer_if.slave   fifo
);
    localparam int depth = 1 << address_size;

    localparam logic [address_size:0] depth_count  = (address_size+1)'(depth);
    localparam logic [address_size:0] af_level     = (address_size+1)'(almost_full_level);
    localparam logic [address_size:0] ae_level     = (address_size+1)'(almost_empty_level);
    localparam logic [address_size:0] one_step     = (address_size+1)'(1);

    // Storage array; intentionally not reset so it maps onto block RAM.
    logic [data_size-1:0]  mem [depth];

    logic [address_size:0] wr_ptr_reg;
    logic [address_size:0] rd_ptr_reg;
    logic [address_size:0] count_reg;
    logic [address_size:0] count_next;
    logic [data_size-1:0]  read_data_reg;
    logic                  read_valid_reg;

    logic full_flag;
    logic empty_flag;
    logic wr_acc;
    logic rd_acc;

    // Flags come from registered count only, so no input reaches a flag combinationally.
    assign full_flag  = (count_reg == depth_count);
    assign empty_flag = (count_reg == '0);

    // A full FIFO refuses writes, an empty one refuses reads; the other
    // request in the same cycle still proceeds (no fall-through when empty).
    assign wr_acc = fifo.write_en_i && !full_flag;
    assign rd_acc = fifo.read_en_i  && !empty_flag;

    // Occupancy bookkeeping: simultaneous accepted read and write cancel out.
    always_comb begin
        count_next = count_reg;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + one_step;
            2'b01:   count_next = count_reg - one_step;
            default: count_next = count_reg;
        endcase
    end

    // Memory write port, indexed by the low pointer bits.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr_reg[address_size-1:0]] <= fifo.write_data_i;
        end
    end

    // Pointers, count and the registered read port; reset empties the FIFO at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            read_data_reg  <= '0;
            read_valid_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            read_valid_reg <= rd_acc;
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + one_step;
            end
            if (rd_acc) begin
                // Reads the pre-edge contents, so a same-cycle write is never returned.
                read_data_reg <= mem[rd_ptr_reg[address_size-1:0]];
                rd_ptr_reg    <= rd_ptr_reg + one_step;
            end
        end
    end

    assign fifo.read_data_o    = read_data_reg;
    assign fifo.read_valid_o   = read_valid_reg;
    assign fifo.full_o         = full_flag;
    assign fifo.empty_o        = empty_flag;
    assign fifo.almost_full_o  = (count_reg >= af_level);
    assign fifo.almost_empty_o = (count_reg <= ae_level);
    assign fifo.count_o        = count_reg;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    // Sticky error flags: any request made against a full/empty FIFO is remembered until reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (fifo.write_en_i && full_flag) begin
                overflow_reg <= 1'b1;
            end
            if (fifo.read_en_i && empty_flag) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign fifo.overflow_o  = overflow_reg;
    assign fifo.underflow_o = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench for sync_fifo_buffer: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_sync_fifo_buffer;
    localparam int DS    = 8;
    localparam int AS    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk_i;
    logic rst_n_i;

    sync_fifo_buffer_if #(.data_size(DS), .address_size(AS)) fifo_if ();

    sync_fifo_buffer #(
        .data_size(DS),
        .address_size(AS),
        .almost_full_level(AF),
        .almost_empty_level(AE)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .fifo   (fifo_if.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [DS-1:0] model_q[$];
    logic [DS-1:0] exp_rd;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_unf;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, ":read_data"},    fifo_if.read_data_o,    exp_rd);
        check({tag, ":read_valid"},   fifo_if.read_valid_o,   exp_valid);
        check({tag, ":count"},        fifo_if.count_o,        n);
        check({tag, ":full"},         fifo_if.full_o,         n == DEPTH);
        check({tag, ":empty"},        fifo_if.empty_o,        n == 0);
        check({tag, ":almost_full"},  fifo_if.almost_full_o,  n >= AF);
        check({tag, ":almost_empty"}, fifo_if.almost_empty_o, n <= AE);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check({tag, ":overflow"},     fifo_if.overflow_o,     exp_ovf);
        check({tag, ":underflow"},    fifo_if.underflow_o,    exp_unf);
`endif
    endtask

    // One clock: drive at the falling edge, update model at the rising edge, compare at the next falling edge.
    task automatic cycle(input string tag, input logic we, input logic [DS-1:0] wd, input logic re);
        int n;
        fifo_if.write_en_i   = we;
        fifo_if.write_data_i = wd;
        fifo_if.read_en_i    = re;
        @(posedge clk_i);
        n = model_q.size();
        if (we && n == DEPTH) exp_ovf = 1'b1;
        if (re && n == 0)     exp_unf = 1'b1;
        exp_valid = re && (n != 0);
        if (re && n != 0) exp_rd = model_q.pop_front();
        if (we && n != DEPTH) model_q.push_back(wd);
        @(negedge clk_i);
        fifo_if.write_en_i = 1'b0;
        fifo_if.read_en_i  = 1'b0;
        $display("%s: we=%0b wd=%02h re=%0b -> rd=%02h valid=%0b count=%0d",
                 tag, we, wd, re, fifo_if.read_data_o, fifo_if.read_valid_o, fifo_if.count_o);
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_rd    = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    initial begin
        logic [DS-1:0] d;
        logic [DS-1:0] base;
        model_reset();
        rst_n_i              = 1'b0;
        fifo_if.write_en_i   = 1'b0;
        fifo_if.write_data_i = '0;
        fifo_if.read_en_i    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_all("reset");
        check("reset:read_data_const", fifo_if.read_data_o, 32'h0);

        // Fill 0x10..0x17
        base = 8'h10;
        for (int i = 0; i < DEPTH; i++) begin
            d = base + 8'(i);
            cycle("fill", 1'b1, d, 1'b0);
        end
        check("fill:full_const", fifo_if.full_o, 1);
        check("fill:count_const", fifo_if.count_o, 8);

        // Drain 8, in order
        for (int i = 0; i < DEPTH; i++) begin
            cycle("drain", 1'b0, 8'h00, 1'b1);
            check("drain:order", fifo_if.read_data_o, 32'h10 + i);
        end
        check("drain:empty_const", fifo_if.empty_o, 1);

        // Refill, then simultaneous read/write while full
        for (int i = 0; i < DEPTH; i++) begin
            d = base + 8'(i);
            cycle("refill", 1'b1, d, 1'b0);
        end
        cycle("full_both", 1'b1, 8'hAA, 1'b1);
        check("full_both:data", fifo_if.read_data_o, 32'h10);
        check("full_both:count", fifo_if.count_o, 7);
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle("full_drain", 1'b0, 8'h00, 1'b1);
        end
        check("full_drain:last", fifo_if.read_data_o, 32'h17);

        // Empty with both requests: write wins, no fall-through
        cycle("empty_both", 1'b1, 8'h55, 1'b1);
        check("empty_both:no_valid", fifo_if.read_valid_o, 0);
        check("empty_both:count", fifo_if.count_o, 1);
        cycle("empty_next", 1'b0, 8'h00, 1'b1);
        check("empty_next:data", fifo_if.read_data_o, 32'h55);

        // Wrap-around: hold count at 4 with continuous simultaneous traffic
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            cycle("wrap_pre", 1'b1, d, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            cycle("wrap", 1'b1, d, 1'b1);
            check("wrap:count", fifo_if.count_o, 4);
        end
        while (model_q.size() != 0) cycle("wrap_drain", 1'b0, 8'h00, 1'b1);

        // Randomized traffic, biased in phases to reach both full and empty
        for (int i = 0; i < 240; i++) begin
            int wp;
            wp = (i / 60) % 2 == 0 ? 70 : 30;
            d = 8'($urandom);
            cycle("random", $urandom_range(0, 99) < wp, d, $urandom_range(0, 99) < (100 - wp));
        end

        // Mid-operation reset at count 5
        while (model_q.size() > 5) cycle("pre_rst", 1'b0, 8'h00, 1'b1);
        while (model_q.size() < 5) begin
            d = 8'($urandom);
            cycle("pre_rst", 1'b1, d, 1'b0);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        $display("mid_reset: count=%0d empty=%0b", fifo_if.count_o, fifo_if.empty_o);
        check_all("mid_reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        cycle("post_rst_read", 1'b0, 8'h00, 1'b1);
        check("post_rst_read:no_valid", fifo_if.read_valid_o, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
